// File: rtl/core_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a fast path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | 32 shift-add / restoring-divide iterations
// FIX   | apply result sign, select output half
// DONE  | result latched into o_res, o_done pulses on the following cycle
`timescale 1ns/1ps
module core_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_num1u,
   input  logic [XLEN-1:0] i_num2u,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_res
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] W_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [4:0]          r_cnt;
   logic [2:0]          r_funct3;
   logic [XLEN-1:0]     r_a;
   logic [2*XLEN-1:0]   r_prod;
   logic                r_neg_p;
   logic                r_neg_r;
   logic [XLEN-1:0]     r_result;
   logic [XLEN-1:0]     r_res;
   logic                r_done;

   logic                w_accept;
   logic                w_is_div;
   logic                w_sgn1;
   logic                w_sgn2;
   logic                w_neg1;
   logic                w_neg2;
   logic [XLEN-1:0]     w_mag1;
   logic [XLEN-1:0]     w_mag2;
   logic                w_div0;
   logic                w_ovf;
   logic                w_fast;
   logic [XLEN-1:0]     w_fast_res;

   logic [XLEN:0]       w_sum;
   logic [XLEN:0]       w_rem_sh;
   logic                w_ge;
   logic [XLEN-1:0]     w_rem_nxt;
   logic [2*XLEN-1:0]   w_p;
   logic [XLEN-1:0]     w_q;
   logic [XLEN-1:0]     w_r;
   logic [XLEN-1:0]     w_fix_res;

   // r_done blocks re-acceptance while the requester still holds i_start
   assign w_accept = (r_state == S_IDLE) && i_start && !i_flush && !r_done;

   assign w_is_div = i_funct3[2];
   assign w_sgn1   = w_is_div ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
   assign w_sgn2   = w_is_div ? ~i_funct3[0] : ~i_funct3[1];
   assign w_neg1   = w_sgn1 & i_num1u[XLEN-1];
   assign w_neg2   = w_sgn2 & i_num2u[XLEN-1];
   assign w_mag1   = w_neg1 ? (~i_num1u + 1'b1) : i_num1u;
   assign w_mag2   = w_neg2 ? (~i_num2u + 1'b1) : i_num2u;

   assign w_div0   = w_is_div && (i_num2u == '0);
   assign w_ovf    = w_is_div && !i_funct3[0] && (i_num1u == W_MIN_NEG) && (i_num2u == '1);
   assign w_fast   = w_div0 || w_ovf;

   always_comb begin
      w_fast_res = '0;
      if (w_div0)
         w_fast_res = i_funct3[1] ? i_num1u : '1;
      else if (w_ovf)
         w_fast_res = i_funct3[1] ? '0 : W_MIN_NEG;
   end

   // multiply step: add multiplicand into the upper half, shift right
   assign w_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);

   // divide step: {remainder, quotient} shifts left, trial-subtract divisor
   assign w_rem_sh  = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_a});
   assign w_rem_nxt = w_ge ? (w_rem_sh[XLEN-1:0] - r_a) : w_rem_sh[XLEN-1:0];

   assign w_p = r_neg_p ? (~r_prod + 1'b1) : r_prod;
   assign w_q = r_prod[XLEN-1:0];
   assign w_r = r_prod[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_res = '0;
      if (!r_funct3[2])
         w_fix_res = (r_funct3[1:0] == 2'b00) ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN];
      else if (!r_funct3[1])
         w_fix_res = r_neg_p ? (~w_q + 1'b1) : w_q;
      else
         w_fix_res = r_neg_r ? (~w_r + 1'b1) : w_r;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_state_nxt = w_fast ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (i_flush)
               w_state_nxt = S_IDLE;
            else if (r_cnt == 5'd31)
               w_state_nxt = S_FIX;
         end
         S_FIX: begin
            if (i_flush)
               w_state_nxt = S_IDLE;
            else
               w_state_nxt = S_DONE;
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_funct3 <= '0;
         r_a      <= '0;
         r_prod   <= '0;
         r_neg_p  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_res    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         if (r_state == S_DONE)
            r_res <= r_result;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_funct3 <= i_funct3;
                  r_neg_p  <= w_neg1 ^ w_neg2;
                  r_neg_r  <= w_neg1;
                  r_cnt    <= '0;
                  if (w_is_div) begin
                     r_a    <= w_mag2;
                     r_prod <= {{XLEN{1'b0}}, w_mag1};
                  end else begin
                     r_a    <= w_mag1;
                     r_prod <= {{XLEN{1'b0}}, w_mag2};
                  end
                  if (w_fast)
                     r_result <= w_fast_res;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_funct3[2])
                  r_prod <= {w_rem_nxt, r_prod[XLEN-2:0], w_ge};
               else
                  r_prod <= {w_sum, r_prod[XLEN-1:1]};
            end
            S_FIX: r_result <= w_fix_res;
            default: ;
         endcase
      end
   end

   assign o_busy = (r_state != S_IDLE) || r_done;
   assign o_done = r_done;
   assign o_res  = r_res;

endmodule

// File: tb/tb_core_muldiv.sv
// Scoreboard bench for core_muldiv: expected results queued at acceptance,
// compared when o_done pulses; latency, busy, flush and reset behaviour checked inline.
`timescale 1ns/1ps
module tb_core_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic        i_flush;
   logic [2:0]  i_funct3;
   logic [31:0] i_num1u;
   logic [31:0] i_num2u;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_res;

   logic [31:0] q_exp[$];
   logic [31:0] mon_exp;
   logic [31:0] last_exp;
   int          n_vec = 0;
   int          n_err = 0;

   core_muldiv #(.XLEN(32)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_flush  (i_flush),
      .i_funct3 (i_funct3),
      .i_num1u  (i_num1u),
      .i_num2u  (i_num2u),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_res    (o_res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (o_done) begin
         if (q_exp.size() == 0)
            chk("spurious_done", 64'd1, 64'd0);
         else begin
            mon_exp = q_exp.pop_front();
            chk("o_res", {32'd0, o_res}, {32'd0, mon_exp});
         end
      end
   end

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      longint p  = 0;
      logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
      return 34;
   endfunction

   // Requester holds i_start until o_done is seen, then drops it.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
      int k;
      i_start  = 1'b1;
      i_funct3 = f3;
      i_num1u  = a;
      i_num2u  = b;
      @(posedge clk);
      q_exp.push_back(exp);
      last_exp = exp;
      #1;
      chk("busy_after_accept", {63'd0, o_busy}, 64'd1);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!o_done && k < 60);
      chk("latency", 64'(k), 64'(lat));
      i_start = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_after_done", {63'd0, o_busy}, 64'd0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          k;

      rst = 1'b1;
      i_start = 1'b0;
      i_flush = 1'b0;
      i_funct3 = '0;
      i_num1u = '0;
      i_num2u = '0;
      last_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {63'd0, o_busy}, 64'd0);
      chk("reset_done", {63'd0, o_done}, 64'd0);
      chk("reset_res",  {32'd0, o_res},  64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34);
      do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
      do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      do_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34);
      do_op(3'd7, 32'd100,       32'd7,         32'd2,         34);
      do_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      do_op(3'd7, 32'd5,         32'd0,         32'd5,         1);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // flush at iteration 10 of a MUL
      i_start = 1'b1; i_funct3 = 3'd0; i_num1u = 32'd12345; i_num2u = 32'd678;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      i_flush = 1'b1;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      chk("flush_busy", {63'd0, o_busy}, 64'd0);
      chk("flush_res_kept", {32'd0, o_res}, {32'd0, last_exp});
      repeat (40) @(posedge clk);
      #1;
      chk("flush_idle", {63'd0, o_busy}, 64'd0);

      // flush and start together in IDLE: request dropped
      i_start = 1'b1; i_flush = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0; i_flush = 1'b0;
      chk("flush_wins", {63'd0, o_busy}, 64'd0);
      do_op(3'd5, 32'd9, 32'd3, 32'd3, 34);

      // stray i_start pulse while busy is ignored
      i_start = 1'b1; i_funct3 = 3'd4; i_num1u = 32'hFFFF_FF9C; i_num2u = 32'd7;
      @(posedge clk);
      q_exp.push_back(32'hFFFF_FFF2);
      #1;
      i_start = 1'b0;
      k = 0;
      repeat (5) begin @(posedge clk); k++; end
      #1;
      i_start = 1'b1; i_funct3 = 3'd0; i_num1u = 32'd3; i_num2u = 32'd3;
      @(posedge clk);
      k++;
      #1;
      i_start = 1'b0;
      chk("busy_during_pulse", {63'd0, o_busy}, 64'd1);
      while (!o_done && k < 60) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("latency_pulse", 64'(k), 64'd34);
      repeat (40) @(posedge clk);
      #1;
      chk("no_second_done", {63'd0, o_busy}, 64'd0);

      for (int i = 0; i < 14; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
         do_op(f3, a, b, model(f3, a, b), lat_of(f3, a, b));
      end

      // asynchronous reset mid-CALC
      i_start = 1'b1; i_funct3 = 3'd1; i_num1u = 32'hDEAD_BEEF; i_num2u = 32'h1234_5678;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", {63'd0, o_busy}, 64'd0);
      chk("async_rst_done", {63'd0, o_done}, 64'd0);
      chk("async_rst_res",  {32'd0, o_res},  64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(3'd0, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd49, 34);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(q_exp.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
